// File: rtl/hid_kbd_ascii_fifo.sv
// hid_kbd_ascii_fifo
// Turns USB HID keyboard reports into a queue of ASCII characters for the CPU.
// An unread report is snapshotted, its four key slots are scanned one per
// cycle against the previous report, newly pressed keys are translated
// (US layout, Shift-aware) and pushed into a character FIFO. The report is
// then acknowledged upstream with a one-cycle hid_rd pulse.
//
// Optional feature: define KBD_TYPEMATIC_EN to add auto-repeat of a single
// held key (REPEAT_DELAY / REPEAT_RATE parameters, in clk cycles).
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   kbd_status   [15:8] modifiers, [2] lost data, [1] report unread, [0] keyboard
//   kbd_keys     {key4,key3,key2,key1} HID usage codes
//   hid_rd       one-cycle read acknowledge to the HID front-end
//   cpu_pop      pop the FIFO head (ignored when empty)
//   cpu_clr      clear rx_overflow / rx_lost
//   rx_data      FIFO head character, 0x00 when empty
//   rx_valid     FIFO not empty
//   rx_count     number of queued characters
//   rx_overflow  sticky: character dropped because the FIFO was full
//   rx_lost      sticky: upstream reported lost data
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for an unread report
//   S_SCAN | checking key slot idx (0..3) for a new press
//   S_UPD  | storing the snapshot as the previous report
//   S_ACK  | issuing hid_rd
//   S_WAIT | waiting for upstream to drop the unread flag

module hid_kbd_ascii_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
`ifdef KBD_TYPEMATIC_EN
    ,
    parameter logic [23:0] REPEAT_DELAY = 24'd12_000_000,
    parameter logic [23:0] REPEAT_RATE  = 24'd1_200_000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      kbd_status,
    input  logic [31:0]      kbd_keys,
    output logic             hid_rd,
    input  logic             cpu_pop,
    input  logic             cpu_clr,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_overflow,
    output logic             rx_lost
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_UPD, S_ACK, S_WAIT} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] snap_keys;
    logic        snap_shift;
    logic [31:0] prev_keys;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [4:0] bit_off;
    logic [7:0] cur_key;
    logic       in_prev;
    logic [8:0] cur_map;
    logic       scan_push;
    logic       push;
    logic [7:0] push_chr;
    logic       push_ok;
    logic       pop_ok;
    logic       lost_set;
    logic       all_rollover;

    wire unused_status = &{1'b0, kbd_status[15:14], kbd_status[12:9], kbd_status[7:3]};

    // Returns {mapped, character}; mapped=0 for codes without an ASCII form.
    function automatic logic [8:0] ascii_map(input logic [7:0] code, input logic shift);
        logic [8:0] r;
        r = 9'h000;
        if (code >= 8'h04 && code <= 8'h1D)
            r = {1'b1, (shift ? 8'h41 : 8'h61) + (code - 8'h04)};
        else begin
            case (code)
                8'h1E: r = {1'b1, shift ? 8'h21 : 8'h31};
                8'h1F: r = {1'b1, shift ? 8'h40 : 8'h32};
                8'h20: r = {1'b1, shift ? 8'h23 : 8'h33};
                8'h21: r = {1'b1, shift ? 8'h24 : 8'h34};
                8'h22: r = {1'b1, shift ? 8'h25 : 8'h35};
                8'h23: r = {1'b1, shift ? 8'h5E : 8'h36};
                8'h24: r = {1'b1, shift ? 8'h26 : 8'h37};
                8'h25: r = {1'b1, shift ? 8'h2A : 8'h38};
                8'h26: r = {1'b1, shift ? 8'h28 : 8'h39};
                8'h27: r = {1'b1, shift ? 8'h29 : 8'h30};
                8'h28: r = {1'b1, 8'h0D};
                8'h29: r = {1'b1, 8'h1B};
                8'h2A: r = {1'b1, 8'h08};
                8'h2B: r = {1'b1, 8'h09};
                8'h2C: r = {1'b1, 8'h20};
                8'h2D: r = {1'b1, shift ? 8'h5F : 8'h2D};
                8'h2E: r = {1'b1, shift ? 8'h2B : 8'h3D};
                8'h2F: r = {1'b1, shift ? 8'h7B : 8'h5B};
                8'h30: r = {1'b1, shift ? 8'h7D : 8'h5D};
                8'h31: r = {1'b1, shift ? 8'h7C : 8'h5C};
                8'h33: r = {1'b1, shift ? 8'h3A : 8'h3B};
                8'h34: r = {1'b1, shift ? 8'h22 : 8'h27};
                8'h35: r = {1'b1, shift ? 8'h7E : 8'h60};
                8'h36: r = {1'b1, shift ? 8'h3C : 8'h2C};
                8'h37: r = {1'b1, shift ? 8'h3E : 8'h2E};
                8'h38: r = {1'b1, shift ? 8'h3F : 8'h2F};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    // Key slot under test and its new-press qualification
    assign bit_off = {idx, 3'b000};
    assign cur_key = snap_keys[bit_off +: 8];
    assign in_prev = (cur_key == prev_keys[7:0])   || (cur_key == prev_keys[15:8]) ||
                     (cur_key == prev_keys[23:16]) || (cur_key == prev_keys[31:24]);
    assign cur_map = ascii_map(cur_key, snap_shift);
    assign scan_push = (state == S_SCAN) && (cur_key != 8'h00) && (cur_key != 8'h01) &&
                       !in_prev && cur_map[8];

    assign all_rollover = (snap_keys == 32'h0101_0101);
    assign lost_set     = (state == S_IDLE) && kbd_status[1] && kbd_status[2];

`ifdef KBD_TYPEMATIC_EN
    logic [23:0] rep_cnt;
    logic [2:0]  held_n;
    logic [7:0]  held_key;
    logic [8:0]  held_map;
    logic        held_ok;
    logic        rep_fire;

    always_comb begin
        held_n   = 3'd0;
        held_key = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (prev_keys[i*8 +: 8] != 8'h00) begin
                held_n   = held_n + 3'd1;
                held_key = prev_keys[i*8 +: 8];
            end
        end
    end

    assign held_map = ascii_map(held_key, snap_shift);
    assign held_ok  = (held_n == 3'd1) && held_map[8];
    assign rep_fire = held_ok && (rep_cnt == 24'd0) && (state != S_UPD);

    // Down-counter reloads on every new report; terminal count fires a repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rep_cnt <= REPEAT_DELAY - 24'd1;
        else if (state == S_UPD || !held_ok)
            rep_cnt <= REPEAT_DELAY - 24'd1;
        else if (rep_cnt == 24'd0)
            rep_cnt <= REPEAT_RATE - 24'd1;
        else
            rep_cnt <= rep_cnt - 24'd1;
    end

    // Scan pushes take priority; a colliding repeat is simply skipped.
    assign push     = scan_push || rep_fire;
    assign push_chr = scan_push ? cur_map[7:0] : held_map[7:0];
`else
    assign push     = scan_push;
    assign push_chr = cur_map[7:0];
`endif

    // Report sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            snap_keys  <= 32'h0;
            snap_shift <= 1'b0;
            prev_keys  <= 32'h0;
            hid_rd     <= 1'b0;
        end else begin
            hid_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (kbd_status[1]) begin
                        if (kbd_status[0]) begin
                            snap_keys  <= kbd_keys;
                            snap_shift <= kbd_status[9] | kbd_status[13];
                            idx        <= 2'd0;
                            state      <= S_SCAN;
                        end else begin
                            state <= S_ACK;
                        end
                    end
                end
                S_SCAN: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= S_UPD;
                end
                S_UPD: begin
                    // A full rollover report carries no key information.
                    if (!all_rollover)
                        prev_keys <= snap_keys;
                    state <= S_ACK;
                end
                S_ACK: begin
                    hid_rd <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (!kbd_status[1])
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Character FIFO; a pop frees room for a push in the same cycle.
    assign pop_ok  = cpu_pop && (rx_count != '0);
    assign push_ok = push && ((rx_count != CNT_W'(FIFO_DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_chr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            rx_lost     <= 1'b0;
        end else begin
            if (push && !push_ok)
                rx_overflow <= 1'b1;
            else if (cpu_clr)
                rx_overflow <= 1'b0;
            if (lost_set)
                rx_lost <= 1'b1;
            else if (cpu_clr)
                rx_lost <= 1'b0;
        end
    end

    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
